// File: rtl/seq_encoder_pkg.sv
// Shared types and helpers for the sequential 8-to-3 encoder.
package seq_encoder_pkg;

  localparam int N      = 8;
  localparam int CODE_W = 3;

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_EMIT = 1'b1
  } state_e;

  // True when exactly one request bit remains.
  function automatic logic popcount_is_one(input logic [N-1:0] pending);
    return (pending != '0) && ((pending & (pending - N'(1))) == '0);
  endfunction

endpackage

// File: rtl/seq_encoder_8x3_pri_enc.sv
// Combinational 8-to-3 priority encoder; direction selected by msb_first.
module pri_enc_8x3
  import seq_encoder_pkg::*;
(
  input  logic [N-1:0]      pending,
  input  logic              msb_first,
  output logic [CODE_W-1:0] code
);

  always_comb begin
    code = '0;
    if (msb_first) begin
      // Ascending scan: the last hit is the highest set bit.
      for (int i = 0; i < N; i++) begin
        if (pending[i]) code = CODE_W'(i);
      end
    end else begin
      for (int i = N - 1; i >= 0; i--) begin
        if (pending[i]) code = CODE_W'(i);
      end
    end
  end

endmodule

// File: rtl/seq_encoder_8x3.sv
// Sequential 8-to-3 encoder: accepts a multi-hot vector, emits one index per handshake.
module seq_encoder_8x3
  import seq_encoder_pkg::*;
#(
  parameter int N_P       = N,
  parameter int CODE_W_P  = CODE_W,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                req_valid,
  output logic                req_ready,
  input  logic [N_P-1:0]      req_bits,
  output logic                code_valid,
  input  logic                code_ready,
  output logic [CODE_W_P-1:0] code,
  output logic                last,
  output logic                empty_req
);

  state_e            state_q, state_d;
  logic [N-1:0]      pending_q, pending_d;
  logic              empty_req_q, empty_req_d;
  logic [CODE_W-1:0] enc_code;

  pri_enc_8x3 u_pri_enc (
    .pending   (pending_q),
    .msb_first (MSB_FIRST),
    .code      (enc_code)
  );

  // Outputs depend only on registered state, never on the request inputs.
  assign req_ready  = (state_q == ST_IDLE);
  assign code_valid = (state_q == ST_EMIT);
  assign code       = enc_code;
  assign last       = code_valid && popcount_is_one(pending_q);
  assign empty_req  = empty_req_q;

  always_comb begin
    state_d     = state_q;
    pending_d   = pending_q;
    empty_req_d = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (req_valid) begin
          if (req_bits != '0) begin
            pending_d = req_bits;
            state_d   = ST_EMIT;
          end else begin
            empty_req_d = 1'b1;
          end
        end
      end
      ST_EMIT: begin
        if (code_ready) begin
          pending_d = pending_q & ~(N'(1) << enc_code);
          if (last) state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      pending_q   <= '0;
      empty_req_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      pending_q   <= pending_d;
      empty_req_q <= empty_req_d;
    end
  end

endmodule

// File: tb/tb_seq_encoder_8x3.sv
// Bench: two encoders (MSB-first and LSB-first) share stimulus; a list model predicts codes.
module tb_seq_encoder_8x3;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       req_valid;
  logic [7:0] req_bits;
  logic       code_ready;

  logic       rr_m, cv_m, last_m, er_m;
  logic [2:0] code_m;
  logic       rr_l, cv_l, last_l, er_l;
  logic [2:0] code_l;

  int passed = 0;
  int total  = 0;

  always #5 clk = ~clk;

  seq_encoder_8x3 #(.MSB_FIRST(1'b1)) dut_m (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(rr_m),
    .req_bits(req_bits), .code_valid(cv_m), .code_ready(code_ready),
    .code(code_m), .last(last_m), .empty_req(er_m)
  );

  seq_encoder_8x3 #(.MSB_FIRST(1'b0)) dut_l (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(rr_l),
    .req_bits(req_bits), .code_valid(cv_l), .code_ready(code_ready),
    .code(code_l), .last(last_l), .empty_req(er_l)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // ready_mode: 0 always ready, 1 random ready, 2 stalled for the first 3 EMIT cycles.
  task automatic run_vec(input logic [7:0] bits, input int ready_mode,
                         input bit hold_en, input logic [7:0] hold_bits);
    int qm[$];
    int ql[$];
    int idx;
    int cyc;
    bit cr;
    for (int i = 7; i >= 0; i--) if (bits[i]) qm.push_back(i);
    for (int i = 0; i < 8; i++)  if (bits[i]) ql.push_back(i);

    check("req_ready_before", {rr_m, rr_l}, 2'b11);
    req_valid  = 1'b1;
    req_bits   = bits;
    code_ready = 1'b0;
    tick();
    req_valid = hold_en;
    req_bits  = hold_en ? hold_bits : $urandom_range(0, 255);

    if (qm.size() == 0) begin
      check("empty_pulse", {er_m, er_l}, 2'b11);
      check("empty_no_code", {cv_m, cv_l}, 2'b00);
      check("empty_ready", {rr_m, rr_l}, 2'b11);
      tick();
      check("empty_pulse_end", {er_m, er_l}, 2'b00);
      check("empty_no_code2", {cv_m, cv_l}, 2'b00);
      return;
    end

    check("no_empty_pulse", {er_m, er_l}, 2'b00);
    idx = 0;
    cyc = 0;
    while (idx < qm.size() && cyc < 200) begin
      case (ready_mode)
        0:       cr = 1'b1;
        1:       cr = 1'($urandom_range(0, 1));
        default: cr = (cyc >= 3);
      endcase
      code_ready = cr;
      check("code_valid", {cv_m, cv_l}, 2'b11);
      check("req_ready_emit", {rr_m, rr_l}, 2'b00);
      check("code_msb", 32'(code_m), qm[idx]);
      check("code_lsb", 32'(code_l), ql[idx]);
      check("last", {last_m, last_l}, (idx == qm.size() - 1) ? 2'b11 : 2'b00);
      tick();
      if (cr) idx++;
      cyc++;
    end
    check("codes_done_in_budget", 32'(idx), 32'(qm.size()));
    code_ready = 1'b0;
    check("gap_idle_ready", {rr_m, rr_l}, 2'b11);
    check("gap_no_code", {cv_m, cv_l}, 2'b00);
  endtask

  initial begin
    rst_n      = 1'b0;
    req_valid  = 1'b0;
    req_bits   = 8'h00;
    code_ready = 1'b0;
    #12;
    check("rst_code_valid", {cv_m, cv_l}, 2'b00);
    check("rst_req_ready", {rr_m, rr_l}, 2'b11);
    check("rst_code", {code_m, code_l}, 6'b0);
    check("rst_last_empty", {last_m, last_l, er_m, er_l}, 4'b0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();

    run_vec(8'b1010_0100, 0, 1'b0, 8'h00);
    run_vec(8'h81, 2, 1'b0, 8'h00);
    run_vec(8'h00, 0, 1'b0, 8'h00);
    for (int i = 0; i < 8; i++) run_vec(8'(1 << i), 0, 1'b0, 8'h00);

    // Second vector offered during EMIT must wait for the IDLE gap.
    run_vec(8'hFF, 1, 1'b1, 8'h3C);
    run_vec(8'h3C, 1, 1'b0, 8'h00);

    for (int k = 0; k < 12; k++) run_vec(8'($urandom_range(0, 255)), 1, 1'b0, 8'h00);

    // Reset in the middle of emitting 0xFF.
    req_valid  = 1'b1;
    req_bits   = 8'hFF;
    code_ready = 1'b1;
    tick();
    req_valid = 1'b0;
    check("pre_rst_code", 32'(code_m), 32'd7);
    tick();
    tick();
    tick();
    check("pre_rst_code4", {code_m, code_l}, {3'd4, 3'd3});
    #2;
    rst_n = 1'b0;
    #1;
    check("midrst_code_valid", {cv_m, cv_l}, 2'b00);
    check("midrst_req_ready", {rr_m, rr_l}, 2'b11);
    check("midrst_last", {last_m, last_l}, 2'b00);
    tick();
    rst_n = 1'b1;
    check("midrst_pending", {dut_m.pending_q, dut_l.pending_q}, 16'h0);
    for (int k = 0; k < 4; k++) begin
      tick();
      check("post_rst_no_code", {cv_m, cv_l, er_m, er_l}, 4'b0);
      check("post_rst_ready", {rr_m, rr_l}, 2'b11);
    end
    run_vec(8'h5A, 0, 1'b0, 8'h00);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/seq_encoder_8x3.md
Name: seq_encoder_8x3

Overview:
- Sequential 8-to-3 encoder; the inverse of the team's 3-to-8 decoder.
- Accepts an 8-bit multi-hot request vector via valid/ready.
- Emits the 3-bit index of every set bit, one code per handshake, in fixed priority order.
- Sits between the line-request logic and any consumer that needs binary indices, e.g. to drive a 3x8 decoder downstream.

Parameters:
- N, 8, number of request lines (only 8 is supported).
- CODE_W, 3, code width, equal to clog2(N).
- MSB_FIRST, 1: 1 emits the highest set index first; 0 emits the lowest first.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  reset, asynchronous, active-low.
- req_valid  in  1  request vector present.
- req_ready  out  1  block can accept a vector.
- req_bits  in  N  multi-hot request vector.
- code_valid  out  1  code output valid.
- code_ready  in  1  consumer accepts code.
- code  out  CODE_W  binary index of the current set bit.
- last  out  1  current code is the final one for this vector.
- empty_req  out  1  one-cycle pulse: an all-zero vector was accepted.

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE, pending=0.
  - code_valid=0, code=0, last=0, empty_req=0.
  - req_ready=1, since req_ready is decoded from state==IDLE.
- States are IDLE and EMIT.
- IDLE:
  - req_ready=1, code_valid=0.
  - On req_valid and req_bits!=0: pending<=req_bits, go to EMIT.
  - On req_valid and req_bits==0: vector is consumed; empty_req=1 next cycle only; stay in IDLE.
- EMIT:
  - req_ready=0; req_valid is ignored, and the upstream must hold its vector.
  - code_valid=1.
  - code = index of the highest set bit of pending (MSB_FIRST=1) or the lowest (MSB_FIRST=0). It is combinational from the pending register only, never from inputs.
  - last = 1 when pending has exactly one bit set.
  - On code_valid and code_ready: clear bit [code] of pending.
    - If last=1, go to IDLE.
    - Otherwise stay in EMIT; the next code appears the following cycle.
- Latency: vector accepted at edge t gives the first code_valid after edge t, i.e. in cycle t+1.
- Throughput: one code per cycle while code_ready=1.
- Gap between vectors: exactly one cycle. After last is accepted the block is in IDLE for one cycle with req_ready=1 before the next vector's codes.
- Backpressure: while code_valid=1 and code_ready=0, code, last and pending hold stable.
- Code count: the number of codes emitted per vector equals popcount(req_bits); each index appears exactly once, in strict priority order.
- Reset mid-EMIT: outputs go to reset values immediately. Pending bits are discarded and no residual codes appear after release.
- No combinational path from req_valid/req_bits to any output. code_ready affects only next-state logic.

Decomposition:
- Package seq_encoder_pkg holds:
  - state enum typedef (IDLE, EMIT);
  - localparams N=8, CODE_W=3;
  - a function popcount_is_one(pending).
- One combinational sub-module, pri_enc_8x3:
  - inputs: pending[7:0], msb_first;
  - output: code[2:0];
  - it is instantiated once on the pending register.
- The FSM, pending register and handshake logic live in the top.

Test Plan:
1. MSB_FIRST=1, code_ready=1, req_bits=8'b1010_0100 -> codes 7,5,2 on three consecutive cycles starting the cycle after acceptance; last=1 only with 2; req_ready=1 on the next cycle.
2. req_bits=8'h81, code_ready low for 3 cycles after code_valid rises -> code=7, last=0 held stable for all 3 cycles; then 7, then 0 with last=1.
3. req_bits=8'h00 -> accepted (req_ready=1); empty_req=1 for exactly one cycle; code_valid never asserts.
4. Sweep single-bit vectors 8'h01..8'h80 each with MSB_FIRST=0 and MSB_FIRST=1 -> single code 0..7 matching bit position, last=1 each time.
5. req_bits=8'hFF with random code_ready -> 8 codes 7..0 (or 0..7 when MSB_FIRST=0), each exactly once. A second vector driven during EMIT is held and gets its first code only after the one-cycle IDLE gap.
6. req_bits=8'hFF; drop rst_n after 3 codes accepted -> code_valid=0 asynchronously; after release req_ready=1, pending=0, and no further codes until a new request.
